cover_toggle_collector: RTL and testbench

- Parametrised hardware toggle-coverage collector: it records rising and falling transitions on each bit of a WIDTH-bit probe vector in sticky bitmaps.
- Maintains a running count of covered points, where each bit contributes two points (rise and fall).
- Coverage is read out per bit through a valid/ready request/response port, so no per-cycle DPI call is needed.
- Instantiated once per probed signal group; software or the difftest harness polls it at end of test.

---
 rtl/cover_toggle_collector.sv | 212 +++++++++++++++++++++
 tb/tb_cover_toggle_collector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector
// Toggle-coverage collector for a WIDTH-bit probe vector. It keeps sticky rise
// and fall bitmaps and a running count of covered points (two per bit). Per-bit
// results are read back through a valid/ready request/response port.
// Optional feature macro: COVER_TOGGLE_SATCNT_EN adds a saturating per-bit
// event counter returned on rd_resp_count (tied to 0 when undefined).

module cover_toggle_collector #(
  parameter int WIDTH = 65,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int CNT_W = 8,
  parameter int COV_W = $clog2(2 * WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] probe,
  input  logic             clear,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_resp_valid,
  input  logic             rd_resp_ready,
  output logic             rd_resp_rise,
  output logic             rd_resp_fall,
  output logic             rd_resp_err,
  output logic [CNT_W-1:0] rd_resp_count,
  output logic [COV_W-1:0] covered_cnt,
  output logic             all_covered
);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] prev;
  logic             armed;
  logic [WIDTH-1:0] hit_rise;
  logic [WIDTH-1:0] hit_fall;
  logic [COV_W-1:0] cov_cnt;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] new_rise;
  logic [WIDTH-1:0] new_fall;
  logic [COV_W-1:0] cov_next;

  logic             accept;
  logic             sel_rise;
  logic             sel_fall;
  logic             sel_err;
  logic [CNT_W-1:0] sel_count;

  logic             resp_rise;
  logic             resp_fall;
  logic             resp_err;
  logic [CNT_W-1:0] resp_count;

  // Edge detection: only meaningful once a previous sample exists (armed) and
  // only on enabled cycles, so a disabled probe never produces toggles.
  always_comb begin
    rise = '0;
    fall = '0;
    if (enable && armed) begin
      rise = ~prev & probe;
      fall = prev & ~probe;
    end
  end

  assign new_rise = rise & ~hit_rise;
  assign new_fall = fall & ~hit_fall;

  // Covered count advances only by first-time hits, so it is bounded by
  // 2*WIDTH and can never wrap.
  always_comb begin
    cov_next = cov_cnt;
    for (int i = 0; i < WIDTH; i++) begin
      cov_next = cov_next + COV_W'(new_rise[i]) + COV_W'(new_fall[i]);
    end
  end

  // Sample register and sticky bitmaps; clear wins over toggles in its cycle
  // but prev still tracks the probe so re-arming starts from a fresh value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev     <= '0;
      armed    <= 1'b0;
      hit_rise <= '0;
      hit_fall <= '0;
      cov_cnt  <= '0;
    end else begin
      if (enable) begin
        prev <= probe;
      end
      if (clear) begin
        armed    <= 1'b0;
        hit_rise <= '0;
        hit_fall <= '0;
        cov_cnt  <= '0;
      end else begin
        if (enable) begin
          armed <= 1'b1;
        end
        hit_rise <= hit_rise | rise;
        hit_fall <= hit_fall | fall;
        cov_cnt  <= cov_next;
      end
    end
  end

  assign covered_cnt = cov_cnt;
  assign all_covered = (cov_cnt == COV_W'(2 * WIDTH));

`ifdef COVER_TOGGLE_SATCNT_EN
  logic [CNT_W-1:0] evt_cnt [WIDTH];

  // Per-bit saturating event counters; rise and fall are exclusive per bit so
  // each counter moves by at most one per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        evt_cnt[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < WIDTH; i++) begin
        evt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((rise[i] || fall[i]) && (evt_cnt[i] != {CNT_W{1'b1}})) begin
          evt_cnt[i] <= evt_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`endif

  // Read-side lookup of the bit selected by rd_idx; out-of-range indices read
  // back as all zeros with the error flag set.
  always_comb begin
    sel_rise  = 1'b0;
    sel_fall  = 1'b0;
    sel_count = '0;
    sel_err   = (int'(rd_idx) >= WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(rd_idx) == i) begin
        sel_rise = hit_rise[i];
        sel_fall = hit_fall[i];
`ifdef COVER_TOGGLE_SATCNT_EN
        sel_count = evt_cnt[i];
`endif
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read FSM next-state: accept in IDLE, hold the response in RESP until taken.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req_valid) begin
          accept     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rd_resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Response capture at the accept edge uses pre-update register values, and
  // is untouched afterwards so a later clear cannot disturb a held response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_rise  <= 1'b0;
      resp_fall  <= 1'b0;
      resp_err   <= 1'b0;
      resp_count <= '0;
    end else if (accept) begin
      resp_rise  <= sel_rise;
      resp_fall  <= sel_fall;
      resp_err   <= sel_err;
      resp_count <= sel_count;
    end
  end

  assign rd_req_ready  = reset && (state == IDLE);
  assign rd_resp_valid = (state == RESP);
  assign rd_resp_rise  = rd_resp_valid && resp_rise;
  assign rd_resp_fall  = rd_resp_valid && resp_fall;
  assign rd_resp_err   = rd_resp_valid && resp_err;
  assign rd_resp_count = rd_resp_valid ? resp_count : '0;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector
// Directed bench for cover_toggle_collector at WIDTH=8, IDX_W=4, CNT_W=4.
// Expected count values depend on COVER_TOGGLE_SATCNT_EN.

module tb_cover_toggle_collector;

  localparam int WIDTH = 8;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int COV_W = $clog2(2 * WIDTH + 1);

`ifdef COVER_TOGGLE_SATCNT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] probe;
  logic             clear;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_resp_valid;
  logic             rd_resp_ready;
  logic             rd_resp_rise;
  logic             rd_resp_fall;
  logic             rd_resp_err;
  logic [CNT_W-1:0] rd_resp_count;
  logic [COV_W-1:0] covered_cnt;
  logic             all_covered;

  int compared;
  int mismatched;

  typedef struct {
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] prb;
    int               exp_cnt;
    logic             exp_all;
  } vec_t;

  vec_t vecs [14];

  cover_toggle_collector #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W),
    .CNT_W(CNT_W),
    .COV_W(COV_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .probe        (probe),
    .clear        (clear),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_idx       (rd_idx),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_resp_rise (rd_resp_rise),
    .rd_resp_fall (rd_resp_fall),
    .rd_resp_err  (rd_resp_err),
    .rd_resp_count(rd_resp_count),
    .covered_cnt  (covered_cnt),
    .all_covered  (all_covered)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One active edge, then settle at the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic en, input logic clr, input logic [WIDTH-1:0] prb);
    enable = en;
    clear  = clr;
    probe  = prb;
    tick();
  endtask

  // Full read with a stalled response for hold cycles.
  task automatic doRead(input string name, input int idx, input int hold,
                        input int exp_rise, input int exp_fall, input int exp_err,
                        input int exp_count);
    rd_idx        = IDX_W'(idx);
    rd_req_valid  = 1'b1;
    rd_resp_ready = 1'b0;
    checkOutput({name, " req_ready idle"}, int'(rd_req_ready), 1);
    tick();
    rd_req_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      checkOutput({name, " valid"}, int'(rd_resp_valid), 1);
      checkOutput({name, " req_ready resp"}, int'(rd_req_ready), 0);
      checkOutput({name, " rise"}, int'(rd_resp_rise), exp_rise);
      checkOutput({name, " fall"}, int'(rd_resp_fall), exp_fall);
      checkOutput({name, " err"}, int'(rd_resp_err), exp_err);
      checkOutput({name, " count"}, int'(rd_resp_count), exp_count);
      if (h < hold) tick();
    end
    rd_resp_ready = 1'b1;
    tick();
    rd_resp_ready = 1'b0;
    checkOutput({name, " valid done"}, int'(rd_resp_valid), 0);
    checkOutput({name, " req_ready back"}, int'(rd_req_ready), 1);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b0;
    enable        = 1'b0;
    clear         = 1'b0;
    probe         = '0;
    rd_req_valid  = 1'b0;
    rd_idx        = '0;
    rd_resp_ready = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 8'h00, 0,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h0F, 4,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 8,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'hFF, 12, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 16, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'hFF, 16, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 16, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'h00, 0,  1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h80, 0,  1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 0,  1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h80, 1,  1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h01, 1,  1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h80, 1,  1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h81, 2,  1'b0};

    // Reset state.
    #12;
    checkOutput("reset req_ready", int'(rd_req_ready), 0);
    checkOutput("reset resp_valid", int'(rd_resp_valid), 0);
    checkOutput("reset covered_cnt", int'(covered_cnt), 0);
    checkOutput("reset all_covered", int'(all_covered), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("post-reset req_ready", int'(rd_req_ready), 1);
    @(negedge clock);

    // Table of sampling vectors.
    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].en, vecs[v].clr, vecs[v].prb);
      checkOutput($sformatf("vec%0d covered_cnt", v), int'(covered_cnt), vecs[v].exp_cnt);
      checkOutput($sformatf("vec%0d all_covered", v), int'(all_covered), int'(vecs[v].exp_all));
    end

    // Reads: bit0 rise only, out-of-range index, bit7 rise only.
    doRead("rd idx0", 0, 3, 1, 0, 0, FEAT ? 1 : 0);
    doRead("rd idx9", 9, 0, 0, 0, 1, 0);
    doRead("rd idx7", 7, 1, 1, 0, 0, FEAT ? 1 : 0);

    // Clear during RESP leaves the held response alone.
    rd_idx        = 4'd0;
    rd_req_valid  = 1'b1;
    tick();
    rd_req_valid  = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h81);
    clear = 1'b0;
    checkOutput("clr-resp valid", int'(rd_resp_valid), 1);
    checkOutput("clr-resp rise", int'(rd_resp_rise), 1);
    checkOutput("clr-resp fall", int'(rd_resp_fall), 0);
    checkOutput("clr-resp covered_cnt", int'(covered_cnt), 0);
    rd_resp_ready = 1'b1;
    tick();
    rd_resp_ready = 1'b0;
    doRead("rd idx0 cleared", 0, 0, 0, 0, 0, 0);

    // Forty toggles on bit 3 after an arming sample.
    applyStimulus(1'b1, 1'b0, 8'h81);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 1'b0, (k % 2 == 0) ? 8'h89 : 8'h81);
    end
    checkOutput("sat covered_cnt", int'(covered_cnt), 2);
    doRead("rd idx3 sat", 3, 0, 1, 1, 0, FEAT ? 15 : 0);

    // Asynchronous reset in the middle of a held response.
    rd_idx       = 4'd3;
    rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    checkOutput("pre-reset resp_valid", int'(rd_resp_valid), 1);
    reset = 1'b0;
    #1;
    checkOutput("async reset resp_valid", int'(rd_resp_valid), 0);
    checkOutput("async reset req_ready", int'(rd_req_ready), 0);
    checkOutput("async reset covered_cnt", int'(covered_cnt), 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
